demux_seq_n: RTL

- Parametrised, registered successor to the 1-to-16 enable demux.
- Routes a single enable strobe to one of N_OUT destinations: the autoencoder's neuron/weight registers and the output buffer.
- Three modes: direct select, auto-scan (internal counter walks outputs 0..N_OUT-1 with stall support), and broadcast.
- Sits between the layer controller and the per-neuron register banks; replaces hand-expanded demux instances.

---
 rtl/demux_seq_n.sv | 115 +++++++++++
 1 files changed

// File: rtl/demux_seq_n.sv
// rtl/demux_seq_n.sv - registered enable demux with direct, auto-scan and broadcast modes
module demux_seq_n #(
  parameter int N_OUT = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] select,
  input  logic             en_in,
  input  logic             start,
  input  logic             clear,
  output logic [N_OUT-1:0] en_out,
  output logic [SEL_W-1:0] cur_idx,
  output logic             busy,
  output logic             done,
  output logic             sel_err
);

  typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

  localparam logic [1:0]       MODE_DIRECT = 2'b00;
  localparam logic [1:0]       MODE_SCAN   = 2'b01;
  localparam logic [1:0]       MODE_BCAST  = 2'b10;
  localparam logic [SEL_W-1:0] LAST_IDX    = SEL_W'(N_OUT - 1);
  // One extra bit so N_OUT == 2**SEL_W still compares correctly.
  localparam logic [SEL_W:0]   N_OUT_EXT   = (SEL_W + 1)'(N_OUT);

  state_t             r_state;
  logic [SEL_W-1:0]   r_idx;
  logic [N_OUT-1:0]   r_en_out;
  logic [SEL_W-1:0]   r_cur_idx;
  logic               r_busy;
  logic               r_done;
  logic               r_sel_err;

  logic               w_sel_ok;
  logic [N_OUT-1:0]   w_sel_onehot;
  logic [N_OUT-1:0]   w_idx_onehot;

  assign w_sel_ok     = ({1'b0, select} < N_OUT_EXT);
  assign w_sel_onehot = N_OUT'(1) << select;
  assign w_idx_onehot = N_OUT'(1) << r_idx;

  // Mode decode and scan FSM; every output is taken straight from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_en_out  <= '0;
      r_cur_idx <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_sel_err <= 1'b0;
      if (clear) begin
        // Abort: cur_idx is deliberately kept so software can see how far it got.
        r_state  <= S_IDLE;
        r_idx    <= '0;
        r_en_out <= '0;
        r_busy   <= 1'b0;
      end else if (r_state == S_SCAN) begin
        // busy stays high through the done cycle and drops on the next one.
        r_busy <= 1'b1;
        if (en_in) begin
          r_en_out  <= w_idx_onehot;
          r_cur_idx <= r_idx;
          if (r_idx == LAST_IDX) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + SEL_W'(1);
          end
        end else begin
          r_en_out <= '0;
        end
      end else begin
        r_busy   <= 1'b0;
        r_en_out <= '0;
        r_idx    <= '0;
        case (mode)
          MODE_DIRECT: begin
            if (en_in) begin
              if (w_sel_ok) begin
                r_en_out  <= w_sel_onehot;
                r_cur_idx <= select;
              end else begin
                r_sel_err <= 1'b1;
              end
            end
          end
          MODE_SCAN: begin
            // en_in in the start cycle is not a scan strobe.
            if (start) begin
              r_state <= S_SCAN;
              r_busy  <= 1'b1;
            end
          end
          MODE_BCAST: r_en_out <= {N_OUT{en_in}};
          default:    r_en_out <= '0;
        endcase
      end
    end
  end

  assign en_out  = r_en_out;
  assign cur_idx = r_cur_idx;
  assign busy    = r_busy;
  assign done    = r_done;
  assign sel_err = r_sel_err;

endmodule
